// File: rtl/const_synth_encoder_if.sv
// Handshake bundle between the program generator, the constant encoder
// and the instruction-memory write port.
interface const_synth_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_last;

   // Request/consume side (generator + memory writer).
   modport master (
      output in_valid, in_value, in_rd, out_ready,
      input  in_ready, out_valid, out_instr, out_last
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_value, in_rd, out_ready,
      output in_ready, out_valid, out_instr, out_last
   );
endinterface

// File: rtl/const_synth_encoder.sv
// Turns a 32-bit constant plus destination register into the SPARC
// sethi / or-immediate word(s) that load exactly that constant.
module const_synth_encoder #(
   parameter bit          ALLOW_SIMM13 = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   const_synth_encoder_if.slave     bus,
   output logic                     busy,
   output logic [CNT_W-1:0]         instr_count
);

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned RD_W      = 5;
   localparam logic [1:0]  OP_SETHI  = 2'b00;
   localparam logic [2:0]  OP2_SETHI = 3'b100;
   localparam logic [1:0]  OP_ARITH  = 2'b10;
   localparam logic [5:0]  OP3_OR    = 6'b000010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EMIT1 = 2'd1,
      EMIT2 = 2'd2
   } state_t;

   state_t             state;
   logic [INSTR_W-1:0] pend_word;

   logic               hs_c;
   logic               accept_c;
   logic               fits_simm13_c;
   logic               low_zero_c;
   logic               single_c;
   logic [INSTR_W-1:0] sethi_word_c;
   logic [INSTR_W-1:0] or_simm_word_c;
   logic [INSTR_W-1:0] or_low_word_c;
   logic [INSTR_W-1:0] first_word_c;
   logic [INSTR_W-1:0] second_word_c;
   logic [RD_W-1:0]    rd_c;

   // Handshakes on both sides; a new request may ride on the final output handshake.
   assign hs_c         = bus.out_valid && bus.out_ready;
   assign bus.in_ready = rst_n && ((state == IDLE) || (hs_c && bus.out_last));
   assign accept_c     = bus.in_valid && bus.in_ready;
   assign busy         = (state != IDLE);

   // Candidate encodings and form selection for the value on the request port.
   always_comb begin
      rd_c           = bus.in_rd;
      fits_simm13_c  = ALLOW_SIMM13 && (bus.in_value[31:12] == {20{bus.in_value[12]}});
      low_zero_c     = (bus.in_value[9:0] == 10'd0);
      sethi_word_c   = {OP_SETHI, rd_c, OP2_SETHI, bus.in_value[31:10]};
      or_simm_word_c = {OP_ARITH, rd_c, OP3_OR, 5'd0, 1'b1, bus.in_value[12:0]};
      or_low_word_c  = {OP_ARITH, rd_c, OP3_OR, rd_c, 1'b1, 3'b000, bus.in_value[9:0]};
      single_c       = 1'b1;
      first_word_c   = sethi_word_c;
      second_word_c  = or_low_word_c;
      if (fits_simm13_c) begin
         first_word_c = or_simm_word_c;
      end else if (!low_zero_c) begin
         single_c = 1'b0;
      end
   end

   // Sequencer: load on accept, advance or retire on output handshake, count words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.out_valid <= 1'b0;
         bus.out_instr <= '0;
         bus.out_last  <= 1'b0;
         pend_word     <= '0;
         instr_count   <= '0;
      end else begin
         if (hs_c) begin
            instr_count <= instr_count + CNT_W'(1);
         end
         if (accept_c) begin
            state         <= EMIT1;
            bus.out_valid <= 1'b1;
            bus.out_instr <= first_word_c;
            bus.out_last  <= single_c;
            pend_word     <= second_word_c;
         end else if (hs_c) begin
            if (bus.out_last) begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end else begin
               state         <= EMIT2;
               bus.out_instr <= pend_word;
               bus.out_last  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_const_synth_encoder.sv
// Scoreboarded bench: unit "a" allows the single-or form, unit "b" does not.
module tb_const_synth_encoder;

   typedef struct packed {
      logic [31:0] w;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        busy_a, busy_b;
   logic [15:0] cnt_a, cnt_b;

   const_synth_encoder_if ia ();
   const_synth_encoder_if ib ();

   const_synth_encoder #(.ALLOW_SIMM13(1'b1), .CNT_W(16)) ua (
      .clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a), .instr_count(cnt_a)
   );
   const_synth_encoder #(.ALLOW_SIMM13(1'b0), .CNT_W(16)) ub (
      .clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b), .instr_count(cnt_b)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   int          words_exp[2];
   bit          rand_rdy = 1'b0;
   bit          pst[2];
   logic [31:0] pin[2];
   logic        plast[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sethi_w(input logic [4:0] rd, input logic [31:0] imm22);
      return (32'(rd) << 25) | (32'd4 << 22) | imm22;
   endfunction

   function automatic logic [31:0] or_w(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm13);
      return 32'h8000_0000 | (32'(rd) << 25) | (32'd2 << 19) | (32'(rs1) << 14)
             | (32'd1 << 13) | imm13;
   endfunction

   // Reference: pick the shortest legal sequence from the value's numeric range.
   function automatic int model(input logic [31:0] v, input logic [4:0] rd, input bit allow,
                                output logic [31:0] w0, output logic [31:0] w1);
      int sv;
      sv = int'(v);
      w1 = '0;
      if (allow && sv >= -4096 && sv <= 4095) begin
         w0 = or_w(rd, 5'd0, v & 32'h0000_1FFF);
         return 1;
      end
      w0 = sethi_w(rd, v / 32'd1024);
      if (v % 32'd1024 == 32'd0) return 1;
      w1 = or_w(rd, rd, v % 32'd1024);
      return 2;
   endfunction

   task automatic push(input bit sel, input logic [31:0] w, input logic last);
      exp_t e;
      e.w    = w;
      e.last = last;
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
   endtask

   // Present one request (called just after a rising edge); returns just after the accepting edge.
   task automatic send(input bit sel, input logic [31:0] v, input logic [4:0] rd);
      logic [31:0] w0, w1;
      int          n;
      bit          done;
      done = 1'b0;
      if (sel) begin ib.in_valid = 1'b1; ib.in_value = v; ib.in_rd = rd; end
      else     begin ia.in_valid = 1'b1; ia.in_value = v; ia.in_rd = rd; end
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if ((sel ? ib.in_ready : ia.in_ready) === 1'b1) begin
            n = model(v, rd, !sel, w0, w1);
            push(sel, w0, n == 1);
            if (n == 2) push(sel, w1, 1'b1);
            words_exp[sel] += n;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: unit %0d value 0x%08h never accepted", sel, v);
      end
      if (sel) begin ib.in_valid = 1'b0; ib.in_value = $urandom; ib.in_rd = 5'($urandom); end
      else     begin ia.in_valid = 1'b0; ia.in_value = $urandom; ia.in_rd = 5'($urandom); end
   endtask

   // Monitor body: stall stability plus in-order scoreboard compare on each handshake.
   task automatic mon(input bit sel, input logic v, input logic r,
                      input logic [31:0] instr, input logic last);
      exp_t e;
      if (pst[sel]) begin
         chk(sel ? "b_stall_valid" : "a_stall_valid", 32'(v), 32'd1);
         chk(sel ? "b_stall_instr" : "a_stall_instr", instr, pin[sel]);
         chk(sel ? "b_stall_last" : "a_stall_last", 32'(last), 32'(plast[sel]));
      end
      if (v && r) begin
         if ((sel ? qb.size() : qa.size()) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: unit %0d got 0x%08h with nothing expected", sel, instr);
         end else begin
            e = sel ? qb.pop_front() : qa.pop_front();
            chk(sel ? "b_instr" : "a_instr", instr, e.w);
            chk(sel ? "b_last" : "a_last", 32'(last), 32'(e.last));
         end
      end
      pst[sel]   = v && !r;
      pin[sel]   = instr;
      plast[sel] = last;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         pst[0] = 1'b0;
         pst[1] = 1'b0;
      end else begin
         mon(1'b0, ia.out_valid, ia.out_ready, ia.out_instr, ia.out_last);
         mon(1'b1, ib.out_valid, ib.out_ready, ib.out_instr, ib.out_last);
      end
   end

   // Random backpressure, only while enabled.
   always @(posedge clk) begin
      #1;
      if (rand_rdy) begin
         ia.out_ready = ($urandom_range(0, 3) != 0);
         ib.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rand_value();
      logic [31:0] corners [8];
      corners = '{32'h0000_0FFF, 32'h0000_1000, 32'hFFFF_F000, 32'hFFFF_EFFF,
                  32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_03FF, 32'hFFFF_FC00};
      case ($urandom_range(0, 3))
         0:       return 32'(int'($urandom_range(0, 8191)) - 4096);
         1:       return $urandom & 32'hFFFF_FC00;
         2:       return $urandom;
         default: return corners[$urandom_range(0, 7)];
      endcase
   endfunction

   initial begin
      logic [31:0] v;
      bit          sel;
      words_exp[0] = 0;
      words_exp[1] = 0;
      rst_n        = 1'b0;
      ia.in_valid  = 1'b0; ia.in_value = '0; ia.in_rd = '0; ia.out_ready = 1'b1;
      ib.in_valid  = 1'b0; ib.in_value = '0; ib.in_rd = '0; ib.out_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      ia.in_valid = 1'b1;
      #1;
      chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
      chk("rst_out_instr", ia.out_instr, 32'd0);
      chk("rst_out_last", 32'(ia.out_last), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_in_ready", 32'(ia.in_ready), 32'd0);
      chk("rst_b_out_valid", 32'(ib.out_valid), 32'd0);
      ia.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero: single or, first word the cycle after acceptance.
      send(1'b0, 32'h0000_0000, 5'd3);
      chk("zero_valid", 32'(ia.out_valid), 32'd1);
      chk("zero_instr", ia.out_instr, 32'h8610_2000);
      chk("zero_last", 32'(ia.out_last), 32'd1);
      chk("zero_busy", 32'(busy_a), 32'd1);
      @(posedge clk); #1;
      chk("zero_count", 32'(cnt_a), 32'd1);
      chk("zero_idle", 32'(busy_a), 32'd0);

      // Most negative simm13.
      send(1'b0, 32'hFFFF_F000, 5'd4);
      chk("neg_instr", ia.out_instr, 32'h8810_3000);
      chk("neg_last", 32'(ia.out_last), 32'd1);
      @(posedge clk); #1;

      // Just past simm13 with clear low bits: single sethi.
      send(1'b0, 32'h0000_1000, 5'd2);
      chk("sethi_instr", ia.out_instr, 32'h0500_0004);
      chk("sethi_last", 32'(ia.out_last), 32'd1);
      @(posedge clk); #1;

      // Pair with a 3-cycle stall on the first word.
      ia.out_ready = 1'b0;
      send(1'b0, 32'h1234_5678, 5'd1);
      chk("pair_w0", ia.out_instr, 32'h0304_8D15);
      chk("pair_w0_last", 32'(ia.out_last), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("stall_instr", ia.out_instr, 32'h0304_8D15);
         chk("stall_in_ready", 32'(ia.in_ready), 32'd0);
      end
      @(posedge clk); #1 ia.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("pair_w1", ia.out_instr, 32'h8210_6278);
      chk("pair_w1_last", 32'(ia.out_last), 32'd1);
      @(posedge clk); #1;
      chk("pair_valid_drop", 32'(ia.out_valid), 32'd0);
      chk("pair_count", 32'(cnt_a), 32'(words_exp[0]));

      // Back-to-back, then reset while the pair's or word is pending.
      send(1'b0, 32'h0000_0000, 5'd7);
      chk("b2b_w0_valid", 32'(ia.out_valid), 32'd1);
      send(1'b0, 32'h1234_5678, 5'd1);
      chk("b2b_w1", ia.out_instr, 32'h0304_8D15);
      @(posedge clk); #1;
      chk("b2b_w2_valid", 32'(ia.out_valid), 32'd1);
      chk("b2b_w2", ia.out_instr, 32'h8210_6278);
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(ia.out_valid), 32'd0);
      chk("async_in_ready", 32'(ia.in_ready), 32'd0);
      chk("async_busy", 32'(busy_a), 32'd0);
      qa.delete();
      qb.delete();
      words_exp[0] = 0;
      words_exp[1] = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_valid", 32'(ia.out_valid), 32'd0);
      end
      chk("post_rst_count", 32'(cnt_a), 32'd0);
      @(posedge clk); #1;

      // Small value without the simm13 form.
      send(1'b1, 32'h0000_0005, 5'd1);
      chk("nosimm_w0", ib.out_instr, 32'h0300_0000);
      chk("nosimm_w0_last", 32'(ib.out_last), 32'd0);
      @(posedge clk); #1;
      chk("nosimm_w1", ib.out_instr, 32'h8210_6005);
      chk("nosimm_w1_last", 32'(ib.out_last), 32'd1);
      @(posedge clk); #1;
      chk("nosimm_count", 32'(cnt_b), 32'd2);

      // Random traffic with random backpressure on both units.
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         sel = 1'($urandom_range(0, 1));
         v   = rand_value();
         send(sel, v, 5'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      ia.out_ready = 1'b1;
      ib.out_ready = 1'b1;
      for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("drain_a", 32'(qa.size()), 32'd0);
      chk("drain_b", 32'(qb.size()), 32'd0);
      chk("final_count_a", 32'(cnt_a), 32'(words_exp[0]) & 32'h0000_FFFF);
      chk("final_count_b", 32'(cnt_b), 32'(words_exp[1]) & 32'h0000_FFFF);
      chk("final_busy_a", 32'(busy_a), 32'd0);
      chk("final_busy_b", 32'(busy_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
